t5_wbarb: RTL and testbench

T5_WBARB -- requirements
Module: t5_wbarb

---
 rtl/t5_wbarb.sv | 128 ++++++++++++
 tb/tb_t5_wbarb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/t5_wbarb.sv
// Two-master Wishbone arbiter: instruction and data masters share one slave port.
// Round-robin on contention, with a watchdog that converts a stalled transfer into an error.
module t5_wbarb #(
    parameter int XLEN  = 32,
    parameter int TBITS = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            iwb_stb,
    input  logic [XLEN-1:0] iwb_adr,
    output logic            iwb_ack,
    output logic            iwb_err,
    output logic [XLEN-1:0] iwb_dti,
    input  logic            dwb_stb,
    input  logic            dwb_wre,
    input  logic [3:0]      dwb_sel,
    input  logic [XLEN-1:0] dwb_adr,
    input  logic [XLEN-1:0] dwb_dto,
    output logic            dwb_ack,
    output logic            dwb_err,
    output logic [XLEN-1:0] dwb_dti,
    output logic            mwb_stb,
    output logic            mwb_wre,
    output logic [3:0]      mwb_sel,
    output logic [XLEN-1:0] mwb_adr,
    output logic [XLEN-1:0] mwb_dto,
    input  logic            mwb_ack,
    input  logic            mwb_err,
    input  logic [XLEN-1:0] mwb_dti,
    output logic [1:0]      gnt
);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT, TERR} state_t;

    state_t             state_q, state_d;
    logic [TBITS-1:0]   cnt_q, cnt_d;
    logic [TBITS-1:0]   cnt_inc;
    logic               last_q, last_d;   // 0: instruction served last, 1: data
    logic               req_stb;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;
    assign req_stb = (state_q == DGNT) ? dwb_stb : iwb_stb;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (iwb_stb && dwb_stb) begin
                    state_d = last_q ? IGNT : DGNT;
                end else if (iwb_stb) begin
                    state_d = IGNT;
                end else if (dwb_stb) begin
                    state_d = DGNT;
                end
            end
            IGNT, DGNT: begin
                // A slave response beats the watchdog when both land in the same cycle.
                if (mwb_ack || mwb_err || !req_stb) begin
                    state_d = IDLE;
                    last_d  = (state_q == DGNT);
                end else if (&cnt_inc) begin
                    state_d = TERR;
                    last_d  = (state_q == DGNT);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TERR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mwb_stb = 1'b0;
        mwb_wre = 1'b0;
        mwb_sel = 4'h0;
        mwb_adr = '0;
        mwb_dto = '0;
        iwb_ack = 1'b0;
        iwb_err = 1'b0;
        dwb_ack = 1'b0;
        dwb_err = 1'b0;
        gnt     = 2'b00;
        case (state_q)
            IGNT: begin
                gnt     = 2'b01;
                mwb_stb = iwb_stb;
                mwb_sel = 4'hF;
                mwb_adr = iwb_adr;
                iwb_ack = mwb_ack;
                iwb_err = mwb_err;
            end
            DGNT: begin
                gnt     = 2'b10;
                mwb_stb = dwb_stb;
                mwb_wre = dwb_wre;
                mwb_sel = dwb_sel;
                mwb_adr = dwb_adr;
                mwb_dto = dwb_dto;
                dwb_ack = mwb_ack;
                dwb_err = mwb_err;
            end
            TERR: begin
                iwb_err = ~last_q;
                dwb_err = last_q;
            end
            default: ;
        endcase
    end

    assign iwb_dti = mwb_dti;
    assign dwb_dti = mwb_dti;

endmodule

// File: tb/tb_t5_wbarb.sv
// Self-checking bench for t5_wbarb: vector table, corner-case sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_t5_wbarb;

    localparam int XLEN  = 32;
    localparam int TBITS = 4;
    localparam int LIMIT = (1 << TBITS) - 1;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b0;
    logic            iwb_stb = 1'b0;
    logic [XLEN-1:0] iwb_adr = '0;
    logic            iwb_ack, iwb_err;
    logic [XLEN-1:0] iwb_dti;
    logic            dwb_stb = 1'b0;
    logic            dwb_wre = 1'b0;
    logic [3:0]      dwb_sel = 4'h0;
    logic [XLEN-1:0] dwb_adr = '0;
    logic [XLEN-1:0] dwb_dto = '0;
    logic            dwb_ack, dwb_err;
    logic [XLEN-1:0] dwb_dti;
    logic            mwb_stb, mwb_wre;
    logic [3:0]      mwb_sel;
    logic [XLEN-1:0] mwb_adr, mwb_dto;
    logic            mwb_ack = 1'b0;
    logic            mwb_err = 1'b0;
    logic [XLEN-1:0] mwb_dti = '0;
    logic [1:0]      gnt;

    int n_checks = 0;
    int n_fail   = 0;

    t5_wbarb #(.XLEN(XLEN), .TBITS(TBITS)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .iwb_stb(iwb_stb), .iwb_adr(iwb_adr), .iwb_ack(iwb_ack), .iwb_err(iwb_err), .iwb_dti(iwb_dti),
        .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel), .dwb_adr(dwb_adr), .dwb_dto(dwb_dto),
        .dwb_ack(dwb_ack), .dwb_err(dwb_err), .dwb_dti(dwb_dti),
        .mwb_stb(mwb_stb), .mwb_wre(mwb_wre), .mwb_sel(mwb_sel), .mwb_adr(mwb_adr), .mwb_dto(mwb_dto),
        .mwb_ack(mwb_ack), .mwb_err(mwb_err), .mwb_dti(mwb_dti),
        .gnt(gnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       i_stb, d_stb, ack, err;
        logic [1:0] e_gnt;
        logic [4:0] e_flags;   // {mwb_stb, iwb_ack, iwb_err, dwb_ack, dwb_err}
    } vec_t;

    function automatic vec_t mk(logic i, logic d, logic a, logic e, logic [1:0] g, logic [4:0] f);
        vec_t v;
        v.i_stb = i; v.d_stb = d; v.ack = a; v.err = e; v.e_gnt = g; v.e_flags = f;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2ns after the rising edge; outputs are sampled 6ns after it.
    task automatic applyStimulus(input logic i, input logic d, input logic a, input logic e);
        @(posedge sys_clk);
        #2;
        iwb_stb = i; dwb_stb = d; mwb_ack = a; mwb_err = e;
        #4;
    endtask

    task automatic doReset();
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        iwb_stb = 0; dwb_stb = 0; mwb_ack = 0; mwb_err = 0;
        #4;
        checkOutput("reset gnt", 128'(gnt), 128'(2'b00));
        checkOutput("reset flags", 128'({mwb_stb, iwb_ack, iwb_err, dwb_ack, dwb_err}), 128'(0));
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
    endtask

    // Transaction-level model: who owns the bus, how long it has waited, who went last.
    int m_owner;   // 0 none, 1 instruction, 2 data, 3 timeout error cycle
    int m_age;
    int m_last;    // 1 instruction, 2 data

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t vecs[15];
        logic [1:0] eg;
        logic [XLEN-1:0] ea;
        int cycles;

        vecs[0]  = mk(1, 1, 0, 0, 2'b00, 5'b00000);
        vecs[1]  = mk(1, 1, 1, 0, 2'b10, 5'b10010);
        vecs[2]  = mk(1, 1, 0, 0, 2'b00, 5'b00000);
        vecs[3]  = mk(1, 1, 1, 0, 2'b01, 5'b11000);
        vecs[4]  = mk(1, 1, 0, 0, 2'b00, 5'b00000);
        vecs[5]  = mk(1, 1, 1, 0, 2'b10, 5'b10010);
        vecs[6]  = mk(1, 1, 0, 0, 2'b00, 5'b00000);
        vecs[7]  = mk(1, 1, 1, 0, 2'b01, 5'b11000);
        vecs[8]  = mk(0, 1, 0, 0, 2'b00, 5'b00000);
        vecs[9]  = mk(0, 1, 0, 1, 2'b10, 5'b10001);
        vecs[10] = mk(0, 0, 0, 0, 2'b00, 5'b00000);
        vecs[11] = mk(1, 0, 0, 0, 2'b00, 5'b00000);
        vecs[12] = mk(1, 0, 0, 0, 2'b01, 5'b10000);
        vecs[13] = mk(0, 0, 0, 0, 2'b01, 5'b00000);
        vecs[14] = mk(0, 0, 1, 0, 2'b00, 5'b00000);

        iwb_adr = 32'h0000_1000;
        dwb_adr = 32'h0000_2000;
        dwb_wre = 1'b1;
        dwb_sel = 4'h3;
        dwb_dto = 32'hCAFE_0001;
        mwb_dti = 32'h1234_5678;

        // Contention right after reset goes to data, then alternates.
        doReset();
        for (int k = 0; k < 15; k++) begin
            applyStimulus(vecs[k].i_stb, vecs[k].d_stb, vecs[k].ack, vecs[k].err);
            checkOutput($sformatf("vec%0d gnt", k), 128'(gnt), 128'(vecs[k].e_gnt));
            checkOutput($sformatf("vec%0d flags", k),
                        128'({mwb_stb, iwb_ack, iwb_err, dwb_ack, dwb_err}), 128'(vecs[k].e_flags));
            eg = vecs[k].e_gnt;
            ea = (eg == 2'b01) ? iwb_adr : (eg == 2'b10) ? dwb_adr : '0;
            checkOutput($sformatf("vec%0d adr", k), 128'(mwb_adr), 128'(ea));
        end
        checkOutput("dti instr", 128'(iwb_dti), 128'(32'h1234_5678));
        checkOutput("dti data", 128'(dwb_dti), 128'(32'h1234_5678));

        // Single data write after reset.
        doReset();
        dwb_adr = 32'h100; dwb_wre = 1'b1; dwb_sel = 4'hF; dwb_dto = 32'hA5A5_0000;
        applyStimulus(0, 1, 0, 0);
        checkOutput("dwrite idle gnt", 128'(gnt), 128'(2'b00));
        applyStimulus(0, 1, 1, 0);
        checkOutput("dwrite gnt", 128'(gnt), 128'(2'b10));
        checkOutput("dwrite bus", 128'({mwb_stb, mwb_wre, mwb_sel, mwb_adr, mwb_dto}),
                    128'({1'b1, 1'b1, 4'hF, 32'h100, 32'hA5A5_0000}));
        checkOutput("dwrite ack", 128'({dwb_ack, iwb_ack}), 128'(2'b10));
        applyStimulus(0, 0, 0, 0);
        checkOutput("dwrite back idle", 128'(gnt), 128'(2'b00));

        // Instruction fetch with no slave answer: watchdog error.
        doReset();
        iwb_adr = 32'h40;
        applyStimulus(1, 0, 0, 0);
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1, 0, 0, 0);
            if (!mwb_stb) break;
            checkOutput("timeout wait fetch bus", 128'({gnt, mwb_wre, mwb_sel, mwb_adr}),
                        128'({2'b01, 1'b0, 4'hF, 32'h40}));
            cycles++;
        end
        checkOutput("timeout stb cycles", 128'(cycles), 128'(LIMIT));
        checkOutput("timeout terr", 128'({gnt, iwb_err, dwb_err, iwb_ack}), 128'({2'b00, 1'b1, 1'b0, 1'b0}));
        applyStimulus(0, 0, 0, 0);
        checkOutput("timeout after", 128'({gnt, iwb_err}), 128'(0));

        // Ack on the last allowed cycle beats the watchdog.
        doReset();
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < LIMIT - 1; k++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0);
        checkOutput("late ack", 128'({gnt, iwb_ack, iwb_err}), 128'({2'b01, 1'b1, 1'b0}));
        applyStimulus(0, 0, 0, 0);
        checkOutput("late ack no terr", 128'({gnt, iwb_err, dwb_err}), 128'(0));

        // Asynchronous reset in the middle of a data grant.
        doReset();
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("pre-reset grant", 128'({gnt, mwb_stb}), 128'({2'b10, 1'b1}));
        #1;
        sys_rst = 1'b1;
        mwb_ack = 1'b1;
        #1;
        checkOutput("async reset drop", 128'({gnt, mwb_stb, dwb_ack, iwb_ack}), 128'(0));
        iwb_stb = 1'b1; dwb_stb = 1'b1; mwb_ack = 1'b0;
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        applyStimulus(1, 1, 0, 0);
        checkOutput("post-reset to data", 128'(gnt), 128'(2'b10));

        // Data master abandons its request; a stray ack afterwards is ignored.
        doReset();
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("drop still granted", 128'({gnt, mwb_stb, dwb_ack}), 128'({2'b10, 1'b0, 1'b0}));
        applyStimulus(0, 0, 1, 0);
        checkOutput("drop stray ack", 128'({gnt, dwb_ack, iwb_ack, dwb_err, iwb_err}), 128'(0));

        // Randomized traffic against the model.
        doReset();
        m_owner = 0; m_age = 0; m_last = 1;
        for (int k = 0; k < 600; k++) begin
            logic [1:0] xg;
            logic [71:0] xbus;
            logic [3:0] xflags;
            @(posedge sys_clk);
            #2;
            iwb_stb = ($urandom % 10) != 0;
            dwb_stb = ($urandom % 10) != 0;
            mwb_ack = ($urandom % 6) == 0;
            mwb_err = ($urandom % 30) == 0;
            iwb_adr = $urandom;
            dwb_adr = $urandom;
            dwb_dto = $urandom;
            dwb_wre = 1'($urandom);
            dwb_sel = 4'($urandom);
            mwb_dti = $urandom;
            #4;
            xg = 2'b00; xbus = '0; xflags = 4'b0000;
            if (m_owner == 1) begin
                xg = 2'b01;
                xbus = {xg, iwb_stb, 1'b0, 4'hF, iwb_adr, 32'h0};
                xflags = {mwb_ack, mwb_err, 2'b00};
            end else if (m_owner == 2) begin
                xg = 2'b10;
                xbus = {xg, dwb_stb, dwb_wre, dwb_sel, dwb_adr, dwb_dto};
                xflags = {2'b00, mwb_ack, mwb_err};
            end else if (m_owner == 3) begin
                xflags = {1'b0, m_last == 1, 1'b0, m_last == 2};
            end
            checkOutput($sformatf("rand%0d bus", k),
                        128'({gnt, mwb_stb, mwb_wre, mwb_sel, mwb_adr, mwb_dto}), 128'(xbus));
            checkOutput($sformatf("rand%0d resp", k),
                        128'({iwb_ack, iwb_err, dwb_ack, dwb_err}), 128'(xflags));
            checkOutput($sformatf("rand%0d dti", k), 128'({iwb_dti, dwb_dti}), 128'({mwb_dti, mwb_dti}));

            case (m_owner)
                0: begin
                    m_age = 0;
                    if (iwb_stb && dwb_stb) m_owner = (m_last == 1) ? 2 : 1;
                    else if (iwb_stb)       m_owner = 1;
                    else if (dwb_stb)       m_owner = 2;
                end
                1, 2: begin
                    if (mwb_ack || mwb_err || !(m_owner == 1 ? iwb_stb : dwb_stb)) begin
                        m_last = m_owner;
                        m_owner = 0;
                    end else begin
                        m_age++;
                        if (m_age == LIMIT) begin
                            m_last = m_owner;
                            m_owner = 3;
                        end
                    end
                end
                default: m_owner = 0;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
